acq_sequencer: RTL
==================

ACQ_SEQUENCER -- requirements
Module: acq_sequencer

Interface
REQ-001 SHALL have parameter NUM_CH, default 8, number of ADC channels per frame.
REQ-002 SHALL have parameter SAMPLE_W, default 14, bits per channel sample.
REQ-003 SHALL have parameter SETTLE_FRAMES, default 65536, frames discarded after arm before capture.
REQ-004 SHALL have port dco  input  1  sample-domain clock; the only clock.
REQ-005 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have port frame_stb  input  1  one-cycle pulse; a new frame is present on samples.
REQ-007 SHALL have port samples  input  NUM_CH*SAMPLE_W  frame data; channel 0 in the LSBs.
REQ-008 SHALL have port arm  input  1  start an acquisition; level, sampled in IDLE only.
REQ-009 SHALL have port abort  input  1  cancel an acquisition from any state.
REQ-010 SHALL have port capture_len  input  16  frames to capture, sampled on arm.
REQ-011 SHALL have port out_data  output  SAMPLE_W  serialized sample.
REQ-012 SHALL have port out_ch  output  3  channel index of out_data.
REQ-013 SHALL have port out_valid / out_ready  output / input  1 each  valid/ready stream handshake.
REQ-014 SHALL have port busy, done, overrun  output  1 each  status.

Function
REQ-015 SHALL implement states IDLE, SETTLE, CAPTURE, DRAIN.
REQ-016 IDLE: arm=1 -> SETTLE; latch capture_len; clear frame and settle counters; clear overrun.
REQ-017 SETTLE: count frame_stb; on the SETTLE_FRAMES-th pulse -> CAPTURE; that frame is discarded.
REQ-018 CAPTURE: on frame_stb with serializer empty, latch all NUM_CH samples into the holding register and increment the frame counter.
REQ-019 Serializer SHALL present channels 0..NUM_CH-1 in order, one per out_valid&out_ready beat; out_valid SHALL stay high and out_data/out_ch stable until ready.
REQ-020 frame_stb while the serializer is non-empty: drop the frame, do not count it, set overrun (sticky until the next arm).
REQ-021 frame_stb in the same cycle as the last-channel handshake SHALL be accepted (no overrun).
REQ-022 When the frame counter reaches the latched capture_len -> DRAIN; DRAIN waits for the serializer to empty, then pulses done for one cycle -> IDLE.
REQ-023 capture_len=0: SETTLE -> DRAIN directly; no beats are emitted; done pulses.
REQ-024 abort=1 in any state -> IDLE next cycle; the serializer is flushed; out_valid=0; no done pulse; overrun is kept.
REQ-025 abort has priority over arm, frame_stb and handshake completing in the same cycle.
REQ-026 busy SHALL be 1 in every state except IDLE.
REQ-027 Latency SHALL be: frame_stb accepted at cycle N -> out_valid=1 at cycle N+1 carrying channel 0.
REQ-028 Counters SHALL be 16-bit and SHALL not wrap (the terminal condition is an equality compare).

Reset
REQ-029 rst=1 SHALL asynchronously force IDLE, out_valid=0, out_data=0, out_ch=0, busy=0, done=0, overrun=0, and clear all counters and the holding register.
REQ-030 Release of rst SHALL take effect at the next dco edge; arm already high at release starts SETTLE on that edge.

Configuration
REQ-031 With ACQ_TEST_PATTERN_EN defined, the latched value per channel SHALL be {ch[2:0], frame_count[SAMPLE_W-4:0]} instead of samples; otherwise samples are used unchanged.

Structure
REQ-032 Package acq_pkg SHALL hold the state enum, NUM_CH/SAMPLE_W defaults, and the channel-index width.
REQ-033 The holding register, channel counter and handshake SHALL live in sub-module acq_frame_serializer; the FSM and counters live in the top.

Verification
REQ-034 Configure SETTLE_FRAMES=4, capture_len=3, out_ready=1, frame_stb every 16 cycles -> 4 frames dropped, then 24 beats with out_ch 0..7 x3, done pulsed once, overrun=0.
REQ-035 Hold out_ready=0 for 20 cycles during capture -> out_data/out_ch held stable; next frame_stb dropped; overrun=1; frame count excludes the dropped frame.
REQ-036 Align frame_stb with the channel-7 handshake -> new frame accepted, channel 0 valid next cycle, overrun=0.
REQ-037 Assert abort mid-frame at channel 3 -> out_valid=0 next cycle, IDLE, busy=0, no done pulse; re-arm works.
REQ-038 Set capture_len=0 -> no out_valid beats; done pulses after settle; busy returns to 0.
REQ-039 Assert rst mid-CAPTURE, asynchronous to dco -> all outputs 0 immediately; with ACQ_TEST_PATTERN_EN defined, frame 2 channel 5 reads {3'd5, 11'd2}.

Source files
------------

// File: rtl/acq_pkg.sv
// Shared types and defaults for the acquisition sequencer.
package acq_pkg;

  // Sequencer states; exported on the debug port so checkers can bind to them.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SETTLE  = 2'd1,
    CAPTURE = 2'd2,
    DRAIN   = 2'd3
  } acq_state_e;

  localparam int NUM_CH_DEF   = 8;
  localparam int SAMPLE_W_DEF = 14;
  localparam int CH_W         = 3;   // channel index width (out_ch)
  localparam int CNT_W        = 16;  // frame / settle counter width

endpackage

// File: rtl/acq_frame_serializer.sv
// Holds one frame of NUM_CH samples and streams it out one channel per beat.
// Stream handshake: a beat transfers on a clock edge where out_valid and
// out_ready are both 1; while out_valid is 1 and out_ready is 0, out_data and
// out_ch hold their values. flush takes priority over load, and load takes
// priority over a completing beat, so a frame offered on the last-channel
// handshake is captured without a gap.
module acq_frame_serializer
  import acq_pkg::*;
#(
  parameter int NUM_CH   = NUM_CH_DEF,
  parameter int SAMPLE_W = SAMPLE_W_DEF
) (
  input  logic                       dco,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       load,
  input  logic [NUM_CH*SAMPLE_W-1:0] load_data,
  input  logic                       out_ready,
  output logic [SAMPLE_W-1:0]        out_data,
  output logic [CH_W-1:0]            out_ch,
  output logic                       out_valid,
  output logic                       empty,
  output logic                       last_beat
);

  localparam logic [CH_W-1:0] LAST_CH = CH_W'(NUM_CH - 1);

  logic [NUM_CH*SAMPLE_W-1:0] hold;

  // Holding register, channel pointer and valid flag.
  always_ff @(posedge dco or posedge rst) begin
    if (rst) begin
      hold      <= '0;
      out_ch    <= '0;
      out_valid <= 1'b0;
    end else if (flush) begin
      out_ch    <= '0;
      out_valid <= 1'b0;
    end else if (load) begin
      hold      <= load_data;
      out_ch    <= '0;
      out_valid <= 1'b1;
    end else if (out_valid && out_ready) begin
      if (out_ch == LAST_CH) begin
        out_ch    <= '0;
        out_valid <= 1'b0;
      end else begin
        out_ch <= out_ch + 1'b1;
      end
    end
  end

  assign out_data  = hold[int'(out_ch)*SAMPLE_W +: SAMPLE_W];
  assign empty     = ~out_valid;
  assign last_beat = out_valid & out_ready & (out_ch == LAST_CH);

endmodule

// File: rtl/acq_sequencer.sv
// Acquisition sequencer: after arm, discards SETTLE_FRAMES frames, captures
// capture_len frames and serializes each one channel per stream beat.
// Optional build macro: ACQ_TEST_PATTERN_EN replaces the captured samples
// with {channel, frame_count} so the data path can be checked without an ADC.
module acq_sequencer
  import acq_pkg::*;
#(
  parameter int NUM_CH        = NUM_CH_DEF,
  parameter int SAMPLE_W      = SAMPLE_W_DEF,
  parameter int SETTLE_FRAMES = 65536
) (
  input  logic                       dco,
  input  logic                       rst,
  input  logic                       frame_stb,
  input  logic [NUM_CH*SAMPLE_W-1:0] samples,
  input  logic                       arm,
  input  logic                       abort,
  input  logic [CNT_W-1:0]           capture_len,
  output logic [SAMPLE_W-1:0]        out_data,
  output logic [CH_W-1:0]            out_ch,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic                       busy,
  output logic                       done,
  output logic                       overrun,
  output acq_state_e                 state_dbg
);

  // Settle terminal count is SETTLE_FRAMES-1 so 65536 still fits 16 bits.
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_FRAMES - 1);

  acq_state_e                 state;
  logic [CNT_W-1:0]           cap_len;
  logic [CNT_W-1:0]           frame_cnt;
  logic [CNT_W-1:0]           frame_cnt_nxt;
  logic [CNT_W-1:0]           settle_cnt;
  logic                       ser_empty;
  logic                       ser_last;
  logic                       accept_ok;
  logic                       frame_acc;
  logic                       frame_drop;
  logic [NUM_CH*SAMPLE_W-1:0] load_data;

  // A frame fits if the serializer is idle or frees up on this very edge.
  assign accept_ok     = ser_empty | ser_last;
  assign frame_acc     = (state == CAPTURE) & frame_stb & accept_ok & ~abort;
  assign frame_drop    = (state == CAPTURE) & frame_stb & ~accept_ok & ~abort;
  assign frame_cnt_nxt = frame_cnt + 1'b1;
  assign state_dbg     = state;

`ifdef ACQ_TEST_PATTERN_EN
  logic unused_samples;
  assign unused_samples = ^samples;

  // Test pattern: channel index in the top bits, current frame count below.
  always_comb begin
    load_data = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      load_data[c*SAMPLE_W +: SAMPLE_W] = {CH_W'(c), frame_cnt[SAMPLE_W-CH_W-1:0]};
    end
  end
`else
  assign load_data = samples;
`endif

  // Sequencer FSM with counters and registered status outputs.
  always_ff @(posedge dco or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      cap_len    <= '0;
      frame_cnt  <= '0;
      settle_cnt <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      done <= 1'b0;
      if (abort) begin
        state <= IDLE;
        busy  <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (arm) begin
              state      <= SETTLE;
              busy       <= 1'b1;
              cap_len    <= capture_len;
              frame_cnt  <= '0;
              settle_cnt <= '0;
              overrun    <= 1'b0;
            end
          end
          SETTLE: begin
            if (frame_stb) begin
              if (settle_cnt == SETTLE_LAST) begin
                state <= (cap_len == '0) ? DRAIN : CAPTURE;
              end else begin
                settle_cnt <= settle_cnt + 1'b1;
              end
            end
          end
          CAPTURE: begin
            if (frame_acc) begin
              frame_cnt <= frame_cnt_nxt;
              if (frame_cnt_nxt == cap_len) begin
                state <= DRAIN;
              end
            end
            if (frame_drop) begin
              overrun <= 1'b1;
            end
          end
          DRAIN: begin
            if (ser_empty) begin
              state <= IDLE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end
          end
          default: begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

  acq_frame_serializer #(
    .NUM_CH   (NUM_CH),
    .SAMPLE_W (SAMPLE_W)
  ) u_ser (
    .dco       (dco),
    .rst       (rst),
    .flush     (abort),
    .load      (frame_acc),
    .load_data (load_data),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_ch    (out_ch),
    .out_valid (out_valid),
    .empty     (ser_empty),
    .last_beat (ser_last)
  );

endmodule
